// File: rtl/sdram_frame_dma.sv
// Frame-buffer DMA sequencer: N-bank ring between camera write FIFO, SDRAM controller and VGA
// read FIFO. Only complete camera frames are handed to the display.
module sdram_frame_dma #(
  parameter int unsigned NUM_BANKS        = 3,
  parameter int unsigned ADDR_W           = 24,
  parameter int unsigned BANK_W           = 2,
  parameter int unsigned ROW_LSB          = 9,
  parameter int unsigned BURSTS_PER_FRAME = 750,
  parameter int unsigned FIFO_W           = 11,
  parameter int unsigned WR_THRESH        = 512,
  parameter int unsigned RD_THRESH        = 512
) (
  input  logic              clk_133M,
  input  logic              rst_133,
  input  logic              cam_frame_start,
  input  logic              vga_frame_start,
  input  logic [FIFO_W-1:0] wr_fifo_used,
  input  logic [FIFO_W-1:0] rd_fifo_used,
  output logic              wr_sdram_req,
  input  logic              wr_sdram_ack,
  output logic [ADDR_W-1:0] wr_sdram_add,
  output logic              rd_sdram_req,
  input  logic              rd_sdram_ack,
  output logic [ADDR_W-1:0] rd_sdram_add,
  output logic              clear_wrsdram_fifo,
  output logic              clear_rdsdram_fifo,
  output logic [BANK_W-1:0] cam_bank,
  output logic [BANK_W-1:0] vga_bank,
  output logic [15:0]       frame_drop_cnt
);

  localparam int unsigned IDX_W = ADDR_W - BANK_W - ROW_LSB;
  localparam logic [IDX_W-1:0]  LastIdx = IDX_W'(BURSTS_PER_FRAME - 1);
  localparam logic [FIFO_W-1:0] WrThr   = FIFO_W'(WR_THRESH);
  localparam logic [FIFO_W-1:0] RdThr   = FIFO_W'(RD_THRESH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StArm  = 2'd1;
  localparam logic [1:0] StReq  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [BANK_W-1:0] cam_bank_q, cam_bank_d, vga_bank_q, vga_bank_d;
  logic [BANK_W-1:0] last_done_q, last_done_d;
  logic              done_valid_q, done_valid_d;
  logic [15:0]       drop_q, drop_d;
  logic [1:0]        wst_q, wst_d, rst_q, rst_d;
  logic [IDX_W-1:0]  widx_q, widx_d, ridx_q, ridx_d;
  logic              wreq_q, wreq_d, rreq_q, rreq_d;
  logic              wclr_q, wclr_d, rclr_q, rclr_d;
  logic              found;

  always_comb begin
    last_done_d  = last_done_q;
    done_valid_d = done_valid_q;
    vga_bank_d   = vga_bank_q;
    cam_bank_d   = cam_bank_q;
    drop_d       = drop_q;
    found        = 1'b0;

    // Camera update first, then VGA, then pick the new writer bank from the updated pair.
    if (cam_frame_start) begin
      if (wst_q == StDone) begin
        last_done_d  = cam_bank_q;
        done_valid_d = 1'b1;
      end else if (wst_q != StIdle && drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end
    if (vga_frame_start && done_valid_d) begin
      vga_bank_d = last_done_d;
    end
    if (cam_frame_start) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (!found && BANK_W'(b) != vga_bank_d &&
            (!done_valid_d || BANK_W'(b) != last_done_d)) begin
          cam_bank_d = BANK_W'(b);
          found      = 1'b1;
        end
      end
    end

    wst_d  = wst_q;
    widx_d = widx_q;
    wreq_d = wreq_q;
    wclr_d = cam_frame_start;
    if (cam_frame_start) begin
      wst_d  = StArm;
      widx_d = '0;
      wreq_d = 1'b0;
    end else begin
      case (wst_q)
        StArm: if (wr_fifo_used >= WrThr) begin
          wst_d  = StReq;
          wreq_d = 1'b1;
        end
        StReq: if (wr_sdram_ack) begin
          wreq_d = 1'b0;
          if (widx_q == LastIdx) begin
            wst_d = StDone;
          end else begin
            widx_d = widx_q + 1'b1;
            wst_d  = StArm;
          end
        end
        default: ;
      endcase
    end

    rst_d  = rst_q;
    ridx_d = ridx_q;
    rreq_d = rreq_q;
    rclr_d = vga_frame_start;
    if (vga_frame_start) begin
      rst_d  = done_valid_d ? StArm : StIdle;
      ridx_d = '0;
      rreq_d = 1'b0;
    end else begin
      case (rst_q)
        StArm: if (rd_fifo_used <= RdThr) begin
          rst_d  = StReq;
          rreq_d = 1'b1;
        end
        StReq: if (rd_sdram_ack) begin
          rreq_d = 1'b0;
          if (ridx_q == LastIdx) begin
            rst_d = StDone;
          end else begin
            ridx_d = ridx_q + 1'b1;
            rst_d  = StArm;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_133M) begin
    if (rst_133) begin
      cam_bank_q   <= '0;
      vga_bank_q   <= '0;
      last_done_q  <= '0;
      done_valid_q <= 1'b0;
      drop_q       <= '0;
      wst_q        <= StIdle;
      rst_q        <= StIdle;
      widx_q       <= '0;
      ridx_q       <= '0;
      wreq_q       <= 1'b0;
      rreq_q       <= 1'b0;
      wclr_q       <= 1'b0;
      rclr_q       <= 1'b0;
    end else begin
      cam_bank_q   <= cam_bank_d;
      vga_bank_q   <= vga_bank_d;
      last_done_q  <= last_done_d;
      done_valid_q <= done_valid_d;
      drop_q       <= drop_d;
      wst_q        <= wst_d;
      rst_q        <= rst_d;
      widx_q       <= widx_d;
      ridx_q       <= ridx_d;
      wreq_q       <= wreq_d;
      rreq_q       <= rreq_d;
      wclr_q       <= wclr_d;
      rclr_q       <= rclr_d;
    end
  end

  assign wr_sdram_req       = wreq_q;
  assign rd_sdram_req       = rreq_q;
  assign wr_sdram_add       = {cam_bank_q, widx_q, {ROW_LSB{1'b0}}};
  assign rd_sdram_add       = {vga_bank_q, ridx_q, {ROW_LSB{1'b0}}};
  assign clear_wrsdram_fifo = wclr_q;
  assign clear_rdsdram_fifo = rclr_q;
  assign cam_bank           = cam_bank_q;
  assign vga_bank           = vga_bank_q;
  assign frame_drop_cnt     = drop_q;

endmodule

// File: tb/tb_sdram_frame_dma.sv
// Bench for sdram_frame_dma: constant vector table, directed frame sequences and a randomized
// run, all cycles also checked against a frame-level reference model.
module tb_sdram_frame_dma;

  localparam int NB  = 3;
  localparam int BPF = 750;

  logic        clk_133M = 1'b0;
  logic        rst_133 = 1'b1;
  logic        cam_frame_start = 1'b0, vga_frame_start = 1'b0;
  logic [10:0] wr_fifo_used = '0, rd_fifo_used = '0;
  logic        wr_sdram_req, rd_sdram_req;
  logic        wr_sdram_ack = 1'b0, rd_sdram_ack = 1'b0;
  logic [23:0] wr_sdram_add, rd_sdram_add;
  logic        clear_wrsdram_fifo, clear_rdsdram_fifo;
  logic [1:0]  cam_bank, vga_bank;
  logic [15:0] frame_drop_cnt;

  always #5 clk_133M = ~clk_133M;

  sdram_frame_dma dut (
    .clk_133M           (clk_133M),
    .rst_133            (rst_133),
    .cam_frame_start    (cam_frame_start),
    .vga_frame_start    (vga_frame_start),
    .wr_fifo_used       (wr_fifo_used),
    .rd_fifo_used       (rd_fifo_used),
    .wr_sdram_req       (wr_sdram_req),
    .wr_sdram_ack       (wr_sdram_ack),
    .wr_sdram_add       (wr_sdram_add),
    .rd_sdram_req       (rd_sdram_req),
    .rd_sdram_ack       (rd_sdram_ack),
    .rd_sdram_add       (rd_sdram_add),
    .clear_wrsdram_fifo (clear_wrsdram_fifo),
    .clear_rdsdram_fifo (clear_rdsdram_fifo),
    .cam_bank           (cam_bank),
    .vga_bank           (vga_bank),
    .frame_drop_cnt     (frame_drop_cnt)
  );

  int checks = 0, errors = 0, prints = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
    end
  endtask

  // Frame-level reference: counts of bursts per frame, bank bookkeeping by plain search.
  int m_cam, m_vga, m_ld, m_drop;
  bit m_dv, m_seen, m_clrw, m_clrr;
  bit w_busy, w_done, w_req; int w_n;
  bit r_busy, r_req;         int r_n;

  task automatic model_step(input bit cs, vs, rs, input int wu, ru, input bit wa, ra);
    m_clrw = 0;
    m_clrr = 0;
    if (rs) begin
      m_cam = 0; m_vga = 0; m_ld = 0; m_drop = 0; m_dv = 0; m_seen = 0;
      w_busy = 0; w_done = 0; w_req = 0; w_n = 0;
      r_busy = 0; r_req = 0; r_n = 0;
      return;
    end
    if (cs) begin
      if (w_done) begin
        m_ld = m_cam;
        m_dv = 1;
      end else if (m_seen && m_drop < 65535) begin
        m_drop++;
      end
    end
    if (vs && m_dv) m_vga = m_ld;
    if (cs) begin
      for (int b = NB - 1; b >= 0; b--)
        if (b != m_vga && !(m_dv && b == m_ld)) m_cam = b;
      m_seen = 1; w_busy = 1; w_done = 0; w_n = 0; w_req = 0; m_clrw = 1;
    end else if (w_busy) begin
      if (w_req) begin
        if (wa) begin
          w_req = 0;
          if (w_n + 1 == BPF) begin w_busy = 0; w_done = 1; end
          else w_n++;
        end
      end else if (wu >= 512) begin
        w_req = 1;
      end
    end
    if (vs) begin
      m_clrr = 1; r_busy = m_dv; r_n = 0; r_req = 0;
    end else if (r_busy) begin
      if (r_req) begin
        if (ra) begin
          r_req = 0;
          if (r_n + 1 == BPF) r_busy = 0;
          else r_n++;
        end
      end else if (ru <= 512) begin
        r_req = 1;
      end
    end
  endtask

  task automatic cycle(input bit cs, vs, rs, input int wu, ru, input bit wa, ra);
    cam_frame_start = cs;
    vga_frame_start = vs;
    rst_133         = rs;
    wr_fifo_used    = 11'(wu);
    rd_fifo_used    = 11'(ru);
    wr_sdram_ack    = wa;
    rd_sdram_ack    = ra;
    @(posedge clk_133M);
    model_step(cs, vs, rs, wu, ru, wa, ra);
    #1;
    chk("m_wr_req", {31'd0, wr_sdram_req}, 32'(w_req));
    chk("m_wr_add", {8'd0, wr_sdram_add}, 32'((m_cam << 22) | (w_n << 9)));
    chk("m_rd_req", {31'd0, rd_sdram_req}, 32'(r_req));
    chk("m_rd_add", {8'd0, rd_sdram_add}, 32'((m_vga << 22) | (r_n << 9)));
    chk("m_clr_w", {31'd0, clear_wrsdram_fifo}, 32'(m_clrw));
    chk("m_clr_r", {31'd0, clear_rdsdram_fifo}, 32'(m_clrr));
    chk("m_cam_bank", {30'd0, cam_bank}, 32'(m_cam));
    chk("m_vga_bank", {30'd0, vga_bank}, 32'(m_vga));
    chk("m_drop", {16'd0, frame_drop_cnt}, 32'(m_drop));
  endtask

  task automatic wait_wreq(input int ru);
    int t = 0;
    while (!wr_sdram_req && t < 8) begin
      cycle(0, 0, 0, 512, ru, 0, 0);
      t++;
    end
    if (!wr_sdram_req) chk("wr_req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr_burst(input int ru);
    wait_wreq(ru);
    cycle(0, 0, 0, 512, ru, 1, 0);
  endtask

  typedef struct {
    bit cs, vs; int wu, ru; bit wa, ra;
    bit e_wreq; int e_wadd; int e_cam; int e_vga; bit e_rreq; bit e_clrw, e_clrr; int e_drop;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{0, 1,   0, 600, 0, 0, 0, 'h000000, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{1, 0, 512, 600, 0, 0, 0, 'h400000, 1, 0, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 512, 600, 0, 0, 1, 'h400000, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 512, 600, 0, 0, 1, 'h400000, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 512, 600, 1, 0, 0, 'h400200, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 100, 600, 0, 0, 0, 'h400200, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 511, 600, 0, 0, 0, 'h400200, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 600, 600, 0, 0, 1, 'h400200, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 600, 600, 0, 1, 1, 'h400200, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 600, 600, 1, 0, 0, 'h400400, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 600, 600, 0, 0, 0, 'h400000, 1, 0, 0, 1, 0, 1};

    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    chk("reset_wr_req", {31'd0, wr_sdram_req}, 32'd0);
    chk("reset_rd_req", {31'd0, rd_sdram_req}, 32'd0);
    chk("reset_wr_add", {8'd0, wr_sdram_add}, 32'd0);
    chk("reset_cam_bank", {30'd0, cam_bank}, 32'd0);
    chk("reset_vga_bank", {30'd0, vga_bank}, 32'd0);
    chk("reset_drop", {16'd0, frame_drop_cnt}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].cs, tbl[i].vs, 0, tbl[i].wu, tbl[i].ru, tbl[i].wa, tbl[i].ra);
      chk($sformatf("vec%0d_wr_req", i), {31'd0, wr_sdram_req}, 32'(tbl[i].e_wreq));
      chk($sformatf("vec%0d_wr_add", i), {8'd0, wr_sdram_add}, 32'(tbl[i].e_wadd));
      chk($sformatf("vec%0d_cam", i), {30'd0, cam_bank}, 32'(tbl[i].e_cam));
      chk($sformatf("vec%0d_vga", i), {30'd0, vga_bank}, 32'(tbl[i].e_vga));
      chk($sformatf("vec%0d_rd_req", i), {31'd0, rd_sdram_req}, 32'(tbl[i].e_rreq));
      chk($sformatf("vec%0d_rd_add", i), {8'd0, rd_sdram_add}, 32'd0);
      chk($sformatf("vec%0d_clr_w", i), {31'd0, clear_wrsdram_fifo}, 32'(tbl[i].e_clrw));
      chk($sformatf("vec%0d_clr_r", i), {31'd0, clear_rdsdram_fifo}, 32'(tbl[i].e_clrr));
      chk($sformatf("vec%0d_drop", i), {16'd0, frame_drop_cnt}, 32'(tbl[i].e_drop));
    end

    // Full frame into bank 1.
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 512, 600, 0, 0);
    chk("a_cam_bank", {30'd0, cam_bank}, 32'd1);
    chk("a_wr_add0", {8'd0, wr_sdram_add}, 32'h400000);
    chk("a_no_req_yet", {31'd0, wr_sdram_req}, 32'd0);
    cycle(0, 0, 0, 512, 600, 0, 0);
    chk("a_req_high", {31'd0, wr_sdram_req}, 32'd1);
    for (int i = 0; i < BPF; i++) wr_burst(600);
    chk("a_final_add", {8'd0, wr_sdram_add}, 32'h400000 + 32'(749 * 512));
    begin
      bit any_req = 0;
      for (int i = 0; i < 10; i++) begin
        cycle(0, 0, 0, 512, 600, 0, 0);
        any_req |= wr_sdram_req;
      end
      chk("a_done_no_req", {31'd0, any_req}, 32'd0);
    end

    // Simultaneous camera and VGA starts.
    cycle(1, 1, 0, 512, 0, 0, 0);
    chk("b_vga_bank", {30'd0, vga_bank}, 32'd1);
    chk("b_cam_bank", {30'd0, cam_bank}, 32'd0);
    chk("b_rd_add", {8'd0, rd_sdram_add}, 32'h400000);
    chk("b_drop", {16'd0, frame_drop_cnt}, 32'd0);
    cycle(0, 0, 0, 512, 0, 0, 0);
    chk("b_rd_req", {31'd0, rd_sdram_req}, 32'd1);

    // Partial frame after 300 bursts.
    for (int i = 0; i < 300; i++) wr_burst(513);
    wait_wreq(513);
    cycle(1, 0, 0, 512, 513, 0, 0);
    chk("c_drop", {16'd0, frame_drop_cnt}, 32'd1);
    chk("c_req_low", {31'd0, wr_sdram_req}, 32'd0);
    chk("c_cam_bank", {30'd0, cam_bank}, 32'd0);
    cycle(0, 1, 0, 0, 513, 0, 0);
    chk("c_last_done_kept", {30'd0, vga_bank}, 32'd1);

    // Read threshold and stray ack.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 513, 0, 0);
      chk("d_rd_req_513", {31'd0, rd_sdram_req}, 32'd0);
    end
    cycle(0, 0, 0, 0, 513, 0, 1);
    chk("d_stray_req", {31'd0, rd_sdram_req}, 32'd0);
    chk("d_stray_add", {8'd0, rd_sdram_add}, 32'h400000);
    cycle(0, 0, 0, 0, 512, 0, 0);
    chk("d_rd_req_512", {31'd0, rd_sdram_req}, 32'd1);

    // Reset mid-burst.
    wait_wreq(512);
    cycle(0, 0, 1, 512, 512, 0, 0);
    chk("e_wr_req", {31'd0, wr_sdram_req}, 32'd0);
    chk("e_rd_req", {31'd0, rd_sdram_req}, 32'd0);
    chk("e_wr_add", {8'd0, wr_sdram_add}, 32'd0);
    chk("e_rd_add", {8'd0, rd_sdram_add}, 32'd0);
    chk("e_banks", {28'd0, cam_bank, vga_bank}, 32'd0);
    chk("e_drop", {16'd0, frame_drop_cnt}, 32'd0);

    for (int i = 0; i < 40000; i++) begin
      bit cs, vs, rs;
      cs = ($urandom_range(3499) == 0);
      vs = ($urandom_range(499) == 0);
      rs = ($urandom_range(14999) == 0);
      cycle(cs, vs, rs, int'($urandom_range(700, 400)), int'($urandom_range(600, 420)),
            1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
